// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with latched frame config, parity and framing checks
module uart_rx #(
  parameter int CLK_FREQ    = 1843200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in_Rx,
  input  logic [1:0] bd_sel,
  input  logic [1:0] prty_sel,
  input  logic       stop_sel,
  input  logic       data_bit_sel,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int DW = $clog2(CLK_FREQ / 19200 + 1);
  localparam logic [DW-1:0] DIV_1200 = DW'(CLK_FREQ / 19200 - 1);
  localparam logic [DW-1:0] DIV_2400 = DW'(CLK_FREQ / 38400 - 1);
  localparam logic [DW-1:0] DIV_4800 = DW'(CLK_FREQ / 76800 - 1);
  localparam logic [DW-1:0] DIV_9600 = DW'(CLK_FREQ / 153600 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          div_q, div_d, div_max;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d, dout_q, dout_d;
  logic                   acc_q, acc_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [1:0]             bd_q, bd_d, prty_q, prty_d;
  logic                   stop2_q, stop2_d, dbit8_q, dbit8_d;
  logic                   dv_q, dv_d, perr_o_q, perr_o_d, ferr_o_q, ferr_o_d;
  logic                   rx, tick, bit_tick, par_en, fe;

  assign rx       = sync_q[SYNC_STAGES-1];
  assign div_max  = bd_q == 2'd0 ? DIV_1200 : bd_q == 2'd1 ? DIV_2400 : bd_q == 2'd2 ? DIV_4800 : DIV_9600;
  assign tick     = div_q == div_max;
  assign bit_tick = tick && cnt_q == 4'd15;
  assign par_en   = ^prty_q;
  assign fe       = ferr_q | ~rx;

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_o_q;
  assign frame_err  = ferr_o_q;
  assign busy       = state_q != IDLE;

  // Metastability synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], data_in_Rx};
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Divider, bit assembly, latched config and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      acc_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      bd_q     <= '0;
      prty_q   <= '0;
      stop2_q  <= 1'b0;
      dbit8_q  <= 1'b0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      bd_q     <= bd_d;
      prty_q   <= prty_d;
      stop2_q  <= stop2_d;
      dbit8_q  <= dbit8_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
    end
  end

  // Next-state logic; outputs are loaded on entry to DONE so the strobe coincides with DONE
  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    cnt_d    = tick ? cnt_q + 4'd1 : cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    bd_d     = bd_q;
    prty_d   = prty_q;
    stop2_d  = stop2_q;
    dbit8_d  = dbit8_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    case (state_q)
      IDLE: if (!rx) begin
        state_d = START;
        div_d   = '0;
        cnt_d   = '0;
        shift_d = '0;
        acc_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        bd_d    = bd_sel;
        prty_d  = prty_sel;
        stop2_d = stop_sel;
        dbit8_d = data_bit_sel;
      end
      START: if (tick && cnt_q == 4'd7) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (bit_tick) begin
        shift_d = {rx, shift_q[7:1]};
        acc_d   = acc_q ^ rx;
        idx_d   = idx_q + 3'd1;
        if (idx_q == {2'b11, dbit8_q}) state_d = par_en ? PARITY : STOP1;
      end
      PARITY: if (bit_tick) begin
        perr_d  = acc_q ^ rx ^ prty_q[0];
        state_d = STOP1;
      end
      STOP1: if (bit_tick) begin
        ferr_d  = fe;
        state_d = stop2_q ? STOP2 : DONE;
      end
      STOP2: if (bit_tick) begin
        ferr_d  = fe;
        state_d = DONE;
      end
      DONE:    state_d = rx ? IDLE : BREAK;
      BREAK:   state_d = rx ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
    if (state_q != DONE && state_d == DONE) begin
      dv_d     = 1'b1;
      dout_d   = dbit8_q ? shift_q : {1'b0, shift_q[7:1]};
      perr_o_d = perr_q;
      ferr_o_d = fe;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level expectation queue
module tb_uart_rx;
  localparam int CLK_FREQ = 1843200;

  logic       clk = 1'b0, rst = 1'b1, data_in_Rx = 1'b1;
  logic [1:0] bd_sel = 2'd0, prty_sel = 2'd0;
  logic       stop_sel = 1'b0, data_bit_sel = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         due;
  } exp_t;
  exp_t expq[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .data_in_Rx(data_in_Rx), .bd_sel(bd_sel), .prty_sel(prty_sel),
    .stop_sel(stop_sel), .data_bit_sel(data_bit_sel), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] bd);
    return CLK_FREQ / (16 * (1200 << bd));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame with the current config; config is scrambled mid-frame to prove it is latched
  task automatic send(input logic [7:0] d, input logic pbit, input logic stop1_low);
    int div = div_of(bd_sel);
    int nd = data_bit_sel ? 8 : 7;
    logic par_en = prty_sel == 2'd1 || prty_sel == 2'd2;
    logic [1:0] sv_bd = bd_sel, sv_pr = prty_sel;
    logic sv_st = stop_sel, sv_db = data_bit_sel;
    logic bits[$];
    exp_t e;
    e.data = nd == 8 ? d : {1'b0, d[6:0]};
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(d[i]);
    if (par_en) bits.push_back(pbit);
    bits.push_back(~stop1_low);
    if (stop_sel) bits.push_back(1'b1);
    e.perr = par_en && (($countones(e.data) + int'(pbit)) % 2 == (prty_sel == 2'd1 ? 0 : 1));
    e.ferr = stop1_low;
    @(posedge clk);
    #1;
    e.due = cyc + 3 + (16 * bits.size() - 8) * div;
    expq.push_back(e);
    for (int i = 0; i < bits.size(); i++) begin
      data_in_Rx = bits[i];
      if (i == 1) begin
        bd_sel = ~bd_sel;
        prty_sel = ~prty_sel;
        stop_sel = ~stop_sel;
        data_bit_sel = ~data_bit_sel;
      end
      repeat (16 * div) @(posedge clk);
      #1;
    end
    bd_sel = sv_bd;
    prty_sel = sv_pr;
    stop_sel = sv_st;
    data_bit_sel = sv_db;
  endtask

  // Every strobe must match the next expected frame, in content and in cycle
  always @(negedge clk) begin
    if (data_valid) begin : cmp
      exp_t e;
      if (expq.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL unexpected_strobe data_out=%0h cyc=%0d", data_out, cyc);
      end else begin
        e = expq.pop_front();
        chk("strobe_data", data_out, e.data);
        chk("strobe_perr", parity_err, e.perr);
        chk("strobe_ferr", frame_err, e.ferr);
        chk("strobe_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int c0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // 1200 7N1
    bd_sel = 2'd0; prty_sel = 2'd0; stop_sel = 1'b0; data_bit_sel = 1'b0;
    send(8'h2D, 1'b0, 1'b0);
    idle(200);
    chk("t1_pending", expq.size(), 0);
    chk("t1_data", data_out, 8'h2D);
    chk("t1_perr", parity_err, 1'b0);
    chk("t1_ferr", frame_err, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // 2400 8O2: good parity, then bad parity
    bd_sel = 2'd1; prty_sel = 2'd1; stop_sel = 1'b1; data_bit_sel = 1'b1;
    send(8'h2D, 1'b1, 1'b0);
    idle(200);
    chk("t2a_data", data_out, 8'h2D);
    chk("t2a_perr", parity_err, 1'b0);
    chk("t2a_ferr", frame_err, 1'b0);
    send(8'h2D, 1'b0, 1'b0);
    idle(200);
    chk("t2b_data", data_out, 8'h2D);
    chk("t2b_perr", parity_err, 1'b1);
    chk("t2b_ferr", frame_err, 1'b0);

    // 4800 8E1 with the stop bit low
    bd_sel = 2'd2; prty_sel = 2'd2; stop_sel = 1'b0; data_bit_sel = 1'b1;
    send(8'hA5, 1'b0, 1'b1);
    data_in_Rx = 1'b1;
    idle(200);
    chk("t3_data", data_out, 8'hA5);
    chk("t3_perr", parity_err, 1'b0);
    chk("t3_ferr", frame_err, 1'b1);
    chk("t3_busy", busy, 1'b0);

    // 9600 8N1: 48-clk glitch is a false start, then 0xFF
    bd_sel = 2'd3; prty_sel = 2'd0;
    @(posedge clk);
    #1;
    c0 = cyc;
    data_in_Rx = 1'b0;
    idle(48);
    data_in_Rx = 1'b1;
    chk("t4_busy_start", busy, 1'b1);
    while (cyc < c0 + 110) @(negedge clk);
    chk("t4_busy_false", busy, 1'b0);
    chk("t4_no_strobe", data_out, 8'hA5);
    idle(100);
    send(8'hFF, 1'b0, 1'b0);
    idle(100);
    chk("t4_data", data_out, 8'hFF);
    chk("t4_ferr", frame_err, 1'b0);

    // Reset in the middle of data bits of 0x3C
    data_in_Rx = 1'b0;
    idle(3 * 192);
    data_in_Rx = 1'b1;
    idle(192 + 96);
    chk("t5_busy_pre", busy, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_data", data_out, 8'h00);
    chk("t5_valid", data_valid, 1'b0);
    chk("t5_perr", parity_err, 1'b0);
    chk("t5_ferr", frame_err, 1'b0);
    chk("t5_busy", busy, 1'b0);
    idle(16 * 192);
    chk("t5_quiet", data_out, 8'h00);
    send(8'h3C, 1'b0, 1'b0);
    idle(100);
    chk("t5_data_after", data_out, 8'h3C);

    // Break at 1200 7N1: two frame times low, one strobe, then re-arm
    bd_sel = 2'd0; prty_sel = 2'd0; stop_sel = 1'b0; data_bit_sel = 1'b0;
    send(8'h00, 1'b0, 1'b1);
    idle(9 * 1536);
    chk("t6_busy_break", busy, 1'b1);
    data_in_Rx = 1'b1;
    idle(100);
    chk("t6_busy_idle", busy, 1'b0);
    chk("t6_data", data_out, 8'h00);
    chk("t6_ferr", frame_err, 1'b1);
    bd_sel = 2'd3; data_bit_sel = 1'b1;
    send(8'h55, 1'b0, 1'b0);
    idle(100);
    chk("t6_data_after", data_out, 8'h55);
    chk("t6_ferr_after", frame_err, 1'b0);
    chk("final_pending", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
